// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: I-cache miss port, D-cache miss/write-back port,
// and the shared main-memory port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_busywait;

  logic              owner;

  // Arbiter view
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
    input  m_readdata, m_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
    output m_read, m_write, m_address, m_writedata, owner
  );

  // Environment view (caches and memory)
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
    output m_readdata, m_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
    input  m_read, m_write, m_address, m_writedata, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-memory port between the I-cache and
// D-cache miss paths; sequences READ/WRITE/BUSYWAIT and stalls the requester.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [DATA_W-1:0] m_writedata_q, m_writedata_d;
  logic [DATA_W-1:0] i_readdata_q, i_readdata_d;
  logic [DATA_W-1:0] d_readdata_q, d_readdata_d;

  logic i_pend_s;
  logic d_pend_s;
  logic req_any_s;
  logic grant_d_s;
  logic release_s;

  assign i_pend_s  = bus.i_read;
  assign d_pend_s  = bus.d_read | bus.d_write;
  assign req_any_s = i_pend_s | d_pend_s;
  // On a tie the port that did not win last time gets the grant
  assign grant_d_s = d_pend_s & (~i_pend_s | ~owner_q);
  assign release_s = (state_q == S_RELEASE);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_any_s) state_d = S_ISSUE;
        else           state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (bus.m_busywait) state_d = S_WAIT;
        else                state_d = S_ISSUE;
      end
      S_WAIT: begin
        if (!bus.m_busywait) state_d = S_RELEASE;
        else                 state_d = S_WAIT;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered memory strobes, owner and returned blocks
  always_comb begin
    owner_d       = owner_q;
    m_read_d      = m_read_q;
    m_write_d     = m_write_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    i_readdata_d  = i_readdata_q;
    d_readdata_d  = d_readdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_any_s) begin
          owner_d = grant_d_s;
          if (grant_d_s) begin
            // Read+write together is a write; write wins
            m_write_d     = bus.d_write;
            m_read_d      = ~bus.d_write;
            m_address_d   = bus.d_address;
            m_writedata_d = bus.d_writedata;
          end else begin
            m_write_d   = 1'b0;
            m_read_d    = 1'b1;
            m_address_d = bus.i_address;
          end
        end else begin
          owner_d = owner_q;
        end
      end
      S_ISSUE: begin
        m_read_d = m_read_q;
      end
      S_WAIT: begin
        if (!bus.m_busywait) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          if (m_read_q && owner_q) begin
            d_readdata_d = bus.m_readdata;
          end else if (m_read_q) begin
            i_readdata_d = bus.m_readdata;
          end else begin
            d_readdata_d = d_readdata_q;
          end
        end else begin
          m_read_d = m_read_q;
        end
      end
      S_RELEASE: begin
        m_read_d = m_read_q;
      end
      default: begin
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  // Datapath and strobe registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q       <= 1'b0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= {ADDR_W{1'b0}};
      m_writedata_q <= {DATA_W{1'b0}};
      i_readdata_q  <= {DATA_W{1'b0}};
      d_readdata_q  <= {DATA_W{1'b0}};
    end else begin
      owner_q       <= owner_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      i_readdata_q  <= i_readdata_d;
      d_readdata_q  <= d_readdata_d;
    end
  end

  // Stall is combinational so a fresh request stalls in its own cycle
  assign bus.i_busywait  = i_pend_s & ~(release_s & ~owner_q);
  assign bus.d_busywait  = d_pend_s & ~(release_s & owner_q);
  assign bus.m_read      = m_read_q;
  assign bus.m_write     = m_write_q;
  assign bus.m_address   = m_address_q;
  assign bus.m_writedata = m_writedata_q;
  assign bus.i_readdata  = i_readdata_q;
  assign bus.d_readdata  = d_readdata_q;
  assign bus.owner       = owner_q;

endmodule
